// File: rtl/mux_loader_pkg.sv
// Shared types and defaults for the mux operand loader.
package mux_loader_pkg;

    // Loader FSM: collect operand A, collect operand B (+select), hold bundle.
    typedef enum logic [1:0] {
        S_WAIT_A = 2'd0,
        S_WAIT_B = 2'd1,
        S_HOLD   = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 4;

endpackage : mux_loader_pkg

// File: rtl/mux_operand_loader.sv
// Serial operand loader feeding a 2:1 mux.
// Collects data_0 then data_1 (+ select) from one input bus and holds them as a
// registered bundle under an out_valid/out_ready handshake. Operands arriving
// while a bundle is held are dropped and flagged on the sticky overrun output.
// Optional build macro: SEL_AUTO_TOGGLE_EN -- select alternates per completed
// handshake (first bundle after reset uses 0) instead of sampling sel_in.
module mux_operand_loader
    import mux_loader_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             sel_in,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_0,
    output logic [WIDTH-1:0] data_1,
    output logic             sel,
    output logic             out_valid,
    output logic             busy,
    output logic             overrun
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data0_q, data1_q;
    logic             sel_q, sel_d;
    logic             vld_q;
    logic             ovr_q;
    logic             cap_a, cap_b, hshk, drop;

`ifdef SEL_AUTO_TOGGLE_EN
    // Select value to attach to the next bundle; flips on every handshake.
    logic             tgl_q;
`endif

    // Next-state decode and per-cycle strobes.
    always_comb begin
        state_d = state_q;
        cap_a   = 1'b0;
        cap_b   = 1'b0;
        hshk    = 1'b0;
        drop    = 1'b0;
        case (state_q)
            S_WAIT_A: begin
                if (din_valid) begin
                    cap_a   = 1'b1;
                    state_d = S_WAIT_B;
                end
            end
            S_WAIT_B: begin
                if (din_valid) begin
                    cap_b   = 1'b1;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                // A new operand here has nowhere to go; it is discarded even
                // when the handshake completes in the same cycle.
                drop = din_valid;
                if (out_ready) begin
                    hshk    = 1'b1;
                    state_d = S_WAIT_A;
                end
            end
            default: state_d = S_WAIT_A;
        endcase
`ifdef SEL_AUTO_TOGGLE_EN
        sel_d = tgl_q;
`else
        sel_d = sel_in;
`endif
    end

    // State, captured operands and status flags; reset discards any partial bundle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_WAIT_A;
            data0_q <= '0;
            data1_q <= '0;
            sel_q   <= 1'b0;
            vld_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (cap_a) data0_q <= din;
            if (cap_b) begin
                data1_q <= din;
                sel_q   <= sel_d;
            end
            if (cap_b)     vld_q <= 1'b1;
            else if (hshk) vld_q <= 1'b0;
            if (drop) ovr_q <= 1'b1;
        end
    end

`ifdef SEL_AUTO_TOGGLE_EN
    // Alternate the select leg once per consumed bundle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       tgl_q <= 1'b0;
        else if (hshk) tgl_q <= ~tgl_q;
    end
`endif

    assign data_0    = data0_q;
    assign data_1    = data1_q;
    assign sel       = sel_q;
    assign out_valid = vld_q;
    assign busy      = (state_q != S_WAIT_A);
    assign overrun   = ovr_q;

endmodule : mux_operand_loader

// File: tb/tb_mux_operand_loader.sv
// Self-checking bench for mux_operand_loader with a 2:1 mux placed downstream.
// Expected bundles are queued when the second operand is driven and compared
// when the loader presents them.
module tb_mux_operand_loader;

    localparam int W = 4;

    typedef struct packed {
        logic [W-1:0] d0;
        logic [W-1:0] d1;
        logic         s;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] din = '0;
    logic         din_valid = 1'b0;
    logic         sel_in = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] data_0, data_1;
    logic         sel, out_valid, busy, overrun;
    logic [W-1:0] mux_out;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];
    logic tgl_m = 1'b0;

    mux_operand_loader #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .sel_in(sel_in),
        .out_ready(out_ready), .data_0(data_0), .data_1(data_1), .sel(sel),
        .out_valid(out_valid), .busy(busy), .overrun(overrun)
    );

    // Downstream 2:1 mux driven by the loader bundle.
    assign mux_out = sel ? data_1 : data_0;

    always #5 clk = ~clk;

    function automatic logic [W-1:0] gold(input exp_t e);
        return e.s ? e.d1 : e.d0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({data_0, data_1, sel, out_valid, busy, overrun} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got d0=%h d1=%h sel=%b vld=%b busy=%b ovr=%b want all 0",
                     data_0, data_1, sel, out_valid, busy, overrun);
        end
        tick();
        rst = 1'b0;
        sb.delete();
        tgl_m = 1'b0;
    endtask

    task automatic send_op(input logic [W-1:0] d, input logic s);
        din = d; din_valid = 1'b1; sel_in = s;
        tick();
        din_valid = 1'b0; sel_in = 1'b0;
    endtask

    // Drive both operands, queue the expected bundle and check 1-clk latency.
    task automatic send_bundle(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        exp_t e;
        send_op(a, 1'b0);
        send_op(b, s);
`ifdef SEL_AUTO_TOGGLE_EN
        e = '{d0: a, d1: b, s: tgl_m};
`else
        e = '{d0: a, d1: b, s: s};
`endif
        sb.push_back(e);
        checks++;
        if (out_valid !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL bundle_latency: got vld=%b busy=%b want vld=1 busy=1", out_valid, busy);
        end
    endtask

    // Hold the bundle for 'hold' extra cycles, compare it every cycle, then handshake.
    task automatic drain(input int hold);
        exp_t e;
        int   n;
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin tick(); n++; end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL drain_timeout: got vld=%b want 1 within 20 clk", out_valid);
            return;
        end
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL drain_scoreboard: got out_valid with empty queue want queued bundle");
            return;
        end
        e = sb.pop_front();
        for (int i = 0; i <= hold; i++) begin
            checks++;
            if ({out_valid, data_0, data_1, sel, mux_out} !== {1'b1, e.d0, e.d1, e.s, gold(e)}) begin
                errors++;
                $display("FAIL bundle_hold[%0d]: got vld=%b d0=%h d1=%h sel=%b mux=%h want vld=1 d0=%h d1=%h sel=%b mux=%h",
                         i, out_valid, data_0, data_1, sel, mux_out, e.d0, e.d1, e.s, gold(e));
            end
            if (i < hold) tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tgl_m = ~tgl_m;
        checks++;
        if ({out_valid, busy, data_0, data_1, sel} !== {2'b00, e.d0, e.d1, e.s}) begin
            errors++;
            $display("FAIL post_handshake: got vld=%b busy=%b d0=%h d1=%h sel=%b want vld=0 busy=0 d0=%h d1=%h sel=%b",
                     out_valid, busy, data_0, data_1, sel, e.d0, e.d1, e.s);
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({data_0, data_1, sel, out_valid, busy, overrun} !== '0) begin
            errors++;
            $display("FAIL power_on_reset: got nonzero outputs want all 0");
        end
        tick();
        rst = 1'b0;
        send_op(4'h3, 1'b0);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_wait_b: got %b want 1", busy);
        end
        do_reset();
        // Partial operand 3 must be gone: the next operand becomes data_0.
        send_bundle(4'h9, 4'h6, 1'b0);
        drain(0);
    endtask

    task automatic test_basic();
        exp_t e;
        out_ready = 1'b1;
        send_bundle(4'hA, 4'h5, 1'b1);
        e = sb.pop_front();
        checks++;
        if ({data_0, data_1, sel, mux_out} !== {e.d0, e.d1, e.s, gold(e)}) begin
            errors++;
            $display("FAIL basic_bundle: got d0=%h d1=%h sel=%b mux=%h want d0=%h d1=%h sel=%b mux=%h",
                     data_0, data_1, sel, mux_out, e.d0, e.d1, e.s, gold(e));
        end
        tick();
        out_ready = 1'b0;
        tgl_m = ~tgl_m;
        checks++;
        if ({out_valid, data_0, data_1} !== {1'b0, e.d0, e.d1}) begin
            errors++;
            $display("FAIL basic_one_clk: got vld=%b d0=%h d1=%h want vld=0 d0=%h d1=%h",
                     out_valid, data_0, data_1, e.d0, e.d1);
        end
    endtask

    task automatic test_hold();
        send_bundle(4'h7, 4'h2, 1'b0);
        drain(5);
    endtask

    task automatic test_overrun();
        exp_t e;
        send_bundle(4'h1, 4'hC, 1'b1);
        e = sb[0];
        din = 4'hF; din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        checks++;
        if ({overrun, out_valid, busy, data_0, data_1} !== {3'b111, e.d0, e.d1}) begin
            errors++;
            $display("FAIL overrun_drop: got ovr=%b vld=%b busy=%b d0=%h d1=%h want ovr=1 vld=1 busy=1 d0=%h d1=%h",
                     overrun, out_valid, busy, data_0, data_1, e.d0, e.d1);
        end
        drain(0);
        for (int i = 0; i < 2; i++) begin
            send_bundle(4'(i + 4), 4'(i + 8), 1'b0);
            drain(1);
            checks++;
            if (overrun !== 1'b1) begin
                errors++;
                $display("FAIL overrun_sticky[%0d]: got %b want 1", i, overrun);
            end
        end
        // Operand and handshake in the same cycle: dropped, flagged, FSM leaves S_HOLD.
        do_reset();
        send_bundle(4'hD, 4'hE, 1'b1);
        e = sb.pop_front();
        din = 4'hB; din_valid = 1'b1; out_ready = 1'b1;
        tick();
        din_valid = 1'b0; out_ready = 1'b0;
        tgl_m = ~tgl_m;
        checks++;
        if ({overrun, out_valid, busy, data_0, data_1} !== {3'b100, e.d0, e.d1}) begin
            errors++;
            $display("FAIL overrun_with_ready: got ovr=%b vld=%b busy=%b d0=%h d1=%h want ovr=1 vld=0 busy=0 d0=%h d1=%h",
                     overrun, out_valid, busy, data_0, data_1, e.d0, e.d1);
        end
        do_reset();
    endtask

    task automatic test_sel_mode();
        logic want;
        for (int i = 0; i < 4; i++) begin
            send_bundle(4'h3, 4'hC, 1'b0);
`ifdef SEL_AUTO_TOGGLE_EN
            want = (i % 2 == 1);
`else
            want = 1'b0;
`endif
            checks++;
            if (sel !== want) begin
                errors++;
                $display("FAIL sel_mode[%0d]: got %b want %b", i, sel, want);
            end
            drain(0);
        end
    endtask

    task automatic test_exhaustive();
        int start_err;
        start_err = errors;
        for (int s = 0; s < 2; s++)
            for (int a = 0; a < 16; a++)
                for (int b = 0; b < 16; b++) begin
                    send_bundle(4'(a), 4'(b), 1'(s));
                    drain(0);
                end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL exhaustive_leftover: got %0d queued want 0", sb.size());
        end
        $display("Exhaustive sweep: Num_errors=%0d", errors - start_err);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_overrun();
        test_sel_mode();
        do_reset();
        test_exhaustive();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_mux_operand_loader
